// File: rtl/nr_pkg.sv
// Shared constants, FSM state type and multiply op table for the Jacobian multiply scheduler.
package nr_pkg;

    localparam logic [31:0] FP_ONE_NEG = 32'hbf800000;
    localparam logic [31:0] FP_EIGHT   = 32'h41000000;
    localparam logic [31:0] FP_N1250   = 32'hc49c4000;
    localparam logic [31:0] FP_TWO     = 32'h40000000;
    localparam logic [31:0] FP_56P2    = 32'h4260cccd;
    localparam logic [31:0] FP_THREE   = 32'h40400000;
    localparam logic [31:0] FP_NINE    = 32'h41100000;
    localparam logic [31:0] FP_TWENTY  = 32'h41a00000;

    localparam int NUM_OPS = 6;
    localparam int NUM_J   = 12;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        XSel0,
        XSel1,
        XSel2
    } xsel_e;

    typedef struct packed {
        logic [31:0] cval;
        xsel_e       xsel;
        logic [3:0]  slot;
    } op_t;

    function automatic op_t op_entry(input logic [2:0] idx);
        op_t op;
        case (idx)
            3'd0:    op = '{cval: FP_ONE_NEG, xsel: XSel1, slot: 4'd2};
            3'd1:    op = '{cval: FP_EIGHT,   xsel: XSel0, slot: 4'd3};
            3'd2:    op = '{cval: FP_N1250,   xsel: XSel1, slot: 4'd4};
            3'd3:    op = '{cval: FP_TWO,     xsel: XSel1, slot: 4'd7};
            3'd4:    op = '{cval: FP_56P2,    xsel: XSel2, slot: 4'd10};
            default: op = '{cval: FP_56P2,    xsel: XSel1, slot: 4'd11};
        endcase
        return op;
    endfunction

endpackage

// File: rtl/jacobian_mul_sched.sv
// Issues the six variable Jacobian products to one shared fp32 multiplier and publishes J0..J11
// atomically. MUL_TIMEOUT_EN adds a per-product watchdog (TIMEOUT cycles) with a sticky err flag.
module jacobian_mul_sched
  import nr_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] x0,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mul_go,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_p,
  input  logic        mul_stb,
  output logic [31:0] J0,
  output logic [31:0] J1,
  output logic [31:0] J2,
  output logic [31:0] J3,
  output logic [31:0] J4,
  output logic [31:0] J5,
  output logic [31:0] J6,
  output logic [31:0] J7,
  output logic [31:0] J8,
  output logic [31:0] J9,
  output logic [31:0] J10,
  output logic [31:0] J11
);

  state_e state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [31:0] x0_q, x1_q, x2_q;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [NUM_OPS-1:0][31:0] sh_q, sh_d;
  logic [NUM_J-1:0][31:0] j_q, j_d;
  logic [31:0] xc0, xc1, xc2;
  logic accept, load_op, capture, finish, abort;
  op_t nxt_op, fin_op;

  assign accept = (state_q == StIdle) && start;

  // The first operand pair is built from the live inputs since x is latched on the same edge.
  assign xc0 = (state_q == StIdle) ? x0 : x0_q;
  assign xc1 = (state_q == StIdle) ? x1 : x1_q;
  assign xc2 = (state_q == StIdle) ? x2 : x2_q;

`ifdef MUL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  logic [CntW-1:0] cnt_q;
  logic tmo_hit;
  logic err_q;

  assign tmo_hit = 32'(cnt_q) >= TIMEOUT;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        cnt_q <= CntW'(1);
      end else if (state_q == StWait && !mul_stb && !tmo_hit) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (abort) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load_op = 1'b0;
    capture = 1'b0;
    finish  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          idx_d   = 3'd0;
          load_op = 1'b1;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mul_stb) begin
          capture = 1'b1;
          if (idx_q == 3'(NUM_OPS - 1)) begin
            state_d = StDone;
            finish  = 1'b1;
          end else begin
            state_d = StIssue;
            idx_d   = idx_q + 3'd1;
            load_op = 1'b1;
          end
        end
`ifdef MUL_TIMEOUT_EN
        else if (tmo_hit) begin
          state_d = StIdle;
          abort   = 1'b1;
        end
`endif
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    nxt_op = op_entry(idx_d);
    a_d    = a_q;
    b_d    = b_q;
    if (load_op) begin
      a_d = nxt_op.cval;
      case (nxt_op.xsel)
        XSel0:   b_d = xc0;
        XSel1:   b_d = xc1;
        default: b_d = xc2;
      endcase
    end
  end

  always_comb begin
    sh_d = sh_q;
    if (capture) begin
      sh_d[idx_q] = mul_p;
    end
  end

  // The last product comes straight from sh_d so the whole set lands on the done edge.
  always_comb begin
    j_d    = j_q;
    fin_op = op_entry(3'd0);
    if (finish) begin
      j_d[0] = FP_THREE;
      j_d[1] = x2_q;
      j_d[5] = FP_TWO;
      j_d[6] = FP_NINE;
      j_d[8] = FP_TWENTY;
      j_d[9] = FP_ONE_NEG;
      for (int i = 0; i < NUM_OPS; i++) begin
        fin_op = op_entry(3'(i));
        j_d[fin_op.slot] = sh_d[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      x0_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      j_q     <= j_d;
      if (accept) begin
        x0_q <= x0;
        x1_q <= x1;
        x2_q <= x2;
      end
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign mul_go = (state_q == StIssue);
  assign mul_a  = a_q;
  assign mul_b  = b_q;

  assign J0  = j_q[0];
  assign J1  = j_q[1];
  assign J2  = j_q[2];
  assign J3  = j_q[3];
  assign J4  = j_q[4];
  assign J5  = j_q[5];
  assign J6  = j_q[6];
  assign J7  = j_q[7];
  assign J8  = j_q[8];
  assign J9  = j_q[9];
  assign J10 = j_q[10];
  assign J11 = j_q[11];

endmodule

// File: tb/tb_jacobian_mul_sched.sv
// Bench for jacobian_mul_sched: vector table with a J-set scoreboard and a latency-programmable
// multiplier model; the watchdog sequence is built only when MUL_TIMEOUT_EN is defined.
module tb_jacobian_mul_sched;

  typedef logic [11:0][31:0] jset_t;

  typedef struct {
    logic [31:0] x0, x1, x2;
    int          lat;
    logic [31:0] j2, j3, j4, j7, j10, j11;
    int          done_at;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] x0, x1, x2;
  logic        busy, done, err, mul_go;
  logic [31:0] mul_a, mul_b, mul_p;
  logic        mul_stb;
  logic [31:0] J0, J1, J2, J3, J4, J5, J6, J7, J8, J9, J10, J11;

  int n_tests = 0;
  int n_fail  = 0;

  int          lat = 3;
  int          opn = 0;
  int          suppress_op = -1;
  logic [31:0] mx0, mx1, mx2;
  jset_t       sbq[$];
  jset_t       prev_set = '0;
  vec_t        tbl[4];

  always #5 clk = ~clk;

  jacobian_mul_sched #(
    .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .x0(x0),
    .x1(x1),
    .x2(x2),
    .busy(busy),
    .done(done),
    .err(err),
    .mul_go(mul_go),
    .mul_a(mul_a),
    .mul_b(mul_b),
    .mul_p(mul_p),
    .mul_stb(mul_stb),
    .J0(J0),
    .J1(J1),
    .J2(J2),
    .J3(J3),
    .J4(J4),
    .J5(J5),
    .J6(J6),
    .J7(J7),
    .J8(J8),
    .J9(J9),
    .J10(J10),
    .J11(J11)
  );

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic jset_t cur_j();
    jset_t r;
    r[0] = J0;  r[1] = J1;  r[2]  = J2;  r[3]  = J3;
    r[4] = J4;  r[5] = J5;  r[6]  = J6;  r[7]  = J7;
    r[8] = J8;  r[9] = J9;  r[10] = J10; r[11] = J11;
    return r;
  endfunction

  function automatic jset_t make_set(input vec_t v);
    jset_t r;
    r[0] = 32'h40400000; r[1] = v.x2;  r[2] = v.j2;  r[3] = v.j3;
    r[4] = v.j4;         r[5] = 32'h40000000; r[6] = 32'h41100000; r[7] = v.j7;
    r[8] = 32'h41a00000; r[9] = 32'hbf800000; r[10] = v.j10; r[11] = v.j11;
    return r;
  endfunction

  // Exact for the power-of-two x operands used here: scale a's exponent by b's.
  function automatic logic [31:0] fmul_pow2(input logic [31:0] a, input logic [31:0] b);
    logic [7:0] e;
    e = a[30:23] + b[30:23] - 8'd127;
    return {a[31] ^ b[31], e, a[22:0]};
  endfunction

  function automatic logic [31:0] exp_a(input int i);
    logic [31:0] t[6];
    t = '{32'hbf800000, 32'h41000000, 32'hc49c4000, 32'h40000000, 32'h4260cccd, 32'h4260cccd};
    return t[i];
  endfunction

  function automatic logic [31:0] exp_b(input int i);
    case (i)
      1:       return mx0;
      4:       return mx2;
      default: return mx1;
    endcase
  endfunction

  // Multiplier model, stepped 2 time units after each edge so the main flow's
  // drives at +1 are already visible.
  initial begin : mul_model
    logic [31:0] ha, hb;
    int          rem;
    bit          inflight;
    int          cur_op;
    inflight = 0;
    rem = 0;
    cur_op = 0;
    ha = '0;
    hb = '0;
    mul_stb = 1'b0;
    mul_p = '0;
    forever begin
      @(posedge clk);
      #2;
      mul_stb = 1'b0;
      if (rst) begin
        inflight = 0;
      end else begin
        if (inflight) begin
          chk($sformatf("op%0d_a_hold", cur_op), 384'(mul_a), 384'(ha));
          chk($sformatf("op%0d_b_hold", cur_op), 384'(mul_b), 384'(hb));
          rem--;
          if (rem == 0) begin
            inflight = 0;
            if (cur_op != suppress_op) begin
              mul_stb = 1'b1;
              mul_p   = fmul_pow2(ha, hb);
            end
          end
        end
        if (mul_go) begin
          cur_op = opn;
          chk($sformatf("op%0d_a", cur_op), 384'(mul_a), 384'(exp_a(cur_op % 6)));
          chk($sformatf("op%0d_b", cur_op), 384'(mul_b), 384'(exp_b(cur_op % 6)));
          ha = mul_a;
          hb = mul_b;
          rem = lat;
          inflight = 1;
          opn++;
        end
      end
    end
  end

  task automatic run_iter(input vec_t v, input int restart_at, input string tag);
    jset_t exp_set;
    int    k;
    bit    seen;
    @(posedge clk);
    #1;
    x0 = v.x0; x1 = v.x1; x2 = v.x2;
    mx0 = v.x0; mx1 = v.x1; mx2 = v.x2;
    lat = v.lat;
    opn = 0;
    start = 1'b1;
    sbq.push_back(make_set(v));
    k = 0;
    seen = 0;
    while (!seen && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      start = (k == restart_at);
      x1 = (k == restart_at) ? 32'h40400000 : v.x1;
      chk({tag, "_busy"}, 384'(busy), 384'(1'b1));
      if (k == 1) chk({tag, "_err_clear"}, 384'(err), 384'(1'b0));
      if (done) begin
        seen = 1;
        chk({tag, "_done_cycle"}, 384'(k), 384'(v.done_at));
        exp_set = sbq.pop_front();
        for (int i = 0; i < 12; i++) begin
          chk($sformatf("%s_J%0d", tag, i), 384'(cur_j()[i]), 384'(exp_set[i]));
        end
        prev_set = exp_set;
      end else begin
        chk({tag, "_J_hold"}, cur_j(), prev_set);
      end
    end
    if (!seen) begin
      chk({tag, "_done_timeout"}, 384'(seen), 384'(1'b1));
      sbq.delete();
    end
    start = 1'b0;
    x1 = v.x1;
    @(posedge clk);
    #1;
    chk({tag, "_busy_after"}, 384'(busy), 384'(1'b0));
    chk({tag, "_done_after"}, 384'(done), 384'(1'b0));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, 384'(busy), 384'(1'b0));
    chk({tag, "_done"}, 384'(done), 384'(1'b0));
    chk({tag, "_err"}, 384'(err), 384'(1'b0));
    chk({tag, "_mul_go"}, 384'(mul_go), 384'(1'b0));
    chk({tag, "_mul_a"}, 384'(mul_a), 384'(0));
    chk({tag, "_mul_b"}, 384'(mul_b), 384'(0));
    chk({tag, "_J"}, cur_j(), '0);
  endtask

  initial begin : main
    tbl[0] = '{32'h3f800000, 32'h40000000, 32'h3f000000, 3,
               32'hc0000000, 32'h41000000, 32'hc51c4000, 32'h40800000,
               32'h41e0cccd, 32'h42e0cccd, 25};
    tbl[1] = tbl[0];
    tbl[1].lat = 1;
    tbl[1].done_at = 13;
    tbl[2] = tbl[0];
    tbl[2].lat = 7;
    tbl[2].done_at = 49;
    tbl[3] = '{32'h40000000, 32'h3f800000, 32'h40000000, 2,
               32'hbf800000, 32'h41800000, 32'hc49c4000, 32'h40000000,
               32'h42e0cccd, 32'h4260cccd, 19};

    rst = 1'b1; start = 1'b0; x0 = '0; x1 = '0; x2 = '0;
    mx0 = '0; mx1 = '0; mx2 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    for (int i = 0; i < 4; i++) begin
      run_iter(tbl[i], -1, $sformatf("vec%0d", i));
    end

    // start re-asserted mid-iteration with a different x1 must be ignored
    run_iter(tbl[0], 10, "restart");

    // Synchronous reset mid-iteration, then a clean run
    @(posedge clk);
    #1;
    x0 = tbl[0].x0; x1 = tbl[0].x1; x2 = tbl[0].x2;
    mx0 = tbl[0].x0; mx1 = tbl[0].x1; mx2 = tbl[0].x2;
    lat = 3; opn = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("midrst");
    prev_set = '0;
    run_iter(tbl[0], -1, "postrst");

`ifdef MUL_TIMEOUT_EN
    begin : tmo_seq
      int k;
      bit idle_seen, saw_done;
      @(posedge clk);
      #1;
      x0 = tbl[0].x0; x1 = tbl[0].x1; x2 = tbl[0].x2;
      mx0 = tbl[0].x0; mx1 = tbl[0].x1; mx2 = tbl[0].x2;
      lat = 3; opn = 0; suppress_op = 2;
      start = 1'b1;
      k = 0; idle_seen = 0; saw_done = 0;
      while (!idle_seen && k < 100) begin
        @(posedge clk);
        #1;
        k++;
        start = 1'b0;
        if (done) saw_done = 1;
        if (!busy) idle_seen = 1;
        else chk("tmo_J_hold", cur_j(), prev_set);
      end
      chk("tmo_abort", 384'(idle_seen), 384'(1'b1));
      chk("tmo_err", 384'(err), 384'(1'b1));
      chk("tmo_no_done", 384'(saw_done), 384'(1'b0));
      chk("tmo_J_kept", cur_j(), prev_set);
      suppress_op = -1;
      run_iter(tbl[0], -1, "tmo_recover");
      chk("tmo_err_after", 384'(err), 384'(1'b0));
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
